// File: rtl/mod_inv.sv
// Modular inverse mod Q (default 3329) by Fermat exponentiation A^(Q-2), one modular multiply per clock.
// Define MOD_INV_CHECK_EN to add a CHK stage that verifies acc*operand == 1 before reporting the result.
module mod_inv #(
  parameter int Q = 3329
) (
  input  logic        clk,
  input  logic        r,
  input  logic        valid_in,
  input  logic [11:0] A,
  output logic        ready,
  output logic        valid_out,
  output logic [11:0] OUT,
  output logic        zero_err,
  output logic        chk_ok
);

  localparam logic [11:0] EXP       = 12'(Q - 2);
  localparam logic [23:0] BARRETT_M = 24'((48'd1 << 24) / 48'(Q));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    CHK  = 2'd3
  } state_t;

  // Barrett reduction with k = 24: the quotient estimate is at most two short, hence two corrections.
  function automatic logic [11:0] modmul(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] x;
    logic [47:0] t;
    logic [23:0] qe;
    logic [23:0] rr;
    x  = {12'd0, a} * {12'd0, b};
    t  = {24'd0, x} * {24'd0, BARRETT_M};
    qe = 24'(t >> 24);
    rr = x - (qe * 24'(Q));
    if (rr >= 24'(Q)) begin
      rr = rr - 24'(Q);
    end else begin
      rr = rr;
    end
    if (rr >= 24'(Q)) begin
      rr = rr - 24'(Q);
    end else begin
      rr = rr;
    end
    return 12'(rr);
  endfunction

  state_t      state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:0] op_q, op_d;
  logic [11:0] out_q, out_d;
  logic        vout_q, vout_d;
  logic        zerr_q, zerr_d;
  logic        chk_q, chk_d;
  logic        done_s;
  logic [11:0] mul_b_s;
  logic [11:0] prod_s;

  assign mul_b_s   = (state_q == SQR) ? acc_q : op_q;
  assign prod_s    = modmul(acc_q, mul_b_s);
  assign ready     = (state_q == IDLE);
  assign valid_out = vout_q;
  assign OUT       = out_q;
  assign zero_err  = zerr_q;
  assign chk_ok    = chk_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    op_d    = op_q;
    out_d   = out_q;
    vout_d  = 1'b0;
    zerr_d  = zerr_q;
    chk_d   = chk_q;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          op_d    = (A >= 12'(Q)) ? (A - 12'(Q)) : A;
          acc_d   = 12'd1;
          idx_d   = 4'd11;
          state_d = SQR;
        end else begin
          state_d = IDLE;
        end
      end
      SQR: begin
        acc_d = prod_s;
        if (EXP[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == 4'd0) begin
          done_s = 1'b1;
        end else begin
          idx_d = idx_q - 4'd1;
        end
      end
      MUL: begin
        acc_d = prod_s;
        if (idx_q == 4'd0) begin
          done_s = 1'b1;
        end else begin
          idx_d   = idx_q - 4'd1;
          state_d = SQR;
        end
      end
`ifdef MOD_INV_CHECK_EN
      CHK: begin
        state_d = IDLE;
        vout_d  = 1'b1;
        out_d   = acc_q;
        zerr_d  = (op_q == 12'd0);
        chk_d   = (prod_s == 12'd1) || ((op_q == 12'd0) && (acc_q == 12'd0));
        acc_d   = 12'd1;
        idx_d   = 4'd11;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // Last exponent bit consumed: either verify in CHK or publish the result now.
    if (done_s) begin
`ifdef MOD_INV_CHECK_EN
      state_d = CHK;
`else
      state_d = IDLE;
      vout_d  = 1'b1;
      out_d   = prod_s;
      zerr_d  = (op_q == 12'd0);
      chk_d   = 1'b1;
      acc_d   = 12'd1;
      idx_d   = 4'd11;
`endif
    end else begin
      state_d = state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      acc_q   <= 12'd1;
      idx_q   <= 4'd11;
      op_q    <= 12'd0;
      out_q   <= 12'd0;
      vout_q  <= 1'b0;
      zerr_q  <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      out_q   <= out_d;
      vout_q  <= vout_d;
      zerr_q  <= zerr_d;
      chk_q   <= chk_d;
    end
  end

endmodule
